seven_segment_mux: RTL and testbench
====================================

Name: seven_segment_mux

Overview:
Parametrised multiplexed 7-segment display driver. Generalises the fixed 4-digit decimal driver to N digits, hex or decimal display, and decimal points. The combinational divide/modulo chain is replaced by a sequential double-dabble converter. The block sits between the core's status/counter registers and the board display pins, and takes a load-strobed value.

Parameters:
NUM_DIGITS, 4, number of digits driven (1..8)
DATA_W, 16, width of the binary input value
REFRESH_BITS, 18, each digit is held for 2^REFRESH_BITS clocks

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
value  in  DATA_W  binary value to display
load  in  1  single-cycle strobe; captures value, hex_mode and dp_mask
hex_mode  in  1  1 = show hex nibbles, 0 = show decimal
dp_mask  in  NUM_DIGITS  decimal point enable per digit; bit 0 = rightmost digit
busy  out  1  conversion in progress
overflow  out  1  captured value does not fit in NUM_DIGITS
anode  out  NUM_DIGITS  digit enables, active low; bit 0 = rightmost digit
seg  out  7  segments, active low; seg[6]=a .. seg[0]=g
dp  out  1  decimal point, active low

Behaviour:
- Reset (async, reset_n=0):
  - anode all 1s, seg=7'h7F, dp=1.
  - busy=0, overflow=0.
  - Display register all zeros, pending flag 0, prescaler 0, digit index 0.
- Converter FSM: IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE with load=1: capture value, hex_mode and dp_mask. Go to SHIFT if decimal, DONE if hex. busy=1 from the next edge.
  - SHIFT: one double-dabble step per clock (add 3 to each BCD nibble >=5, then shift left). Runs exactly DATA_W cycles. The BCD register holds ceil(DATA_W*0.302)+1 digits.
  - DONE: atomic copy into the display register; busy=0 at the same edge.
  - Decimal latency is DATA_W+1 clocks from load to display update. Hex latency is 1 clock.
  - The scan never shows a partially converted value.
- load while busy:
  - Stored in a one-deep pending register; the last load wins.
  - In DONE, if pending is set, the FSM goes straight to capture from the pending register without passing through IDLE.
  - A load in the same cycle as DONE overwrites pending.
- Overflow:
  - Decimal: overflow if any BCD digit at index >= NUM_DIGITS is nonzero.
  - Hex: overflow if value[DATA_W-1:4*NUM_DIGITS] is nonzero (when DATA_W > 4*NUM_DIGITS).
  - When overflow=1, every digit shows a dash (seg=7'b1111110). dp still follows dp_mask.
  - The flag updates with the display register.
- Scan:
  - The prescaler counts 0..2^REFRESH_BITS-1 and wraps.
  - On wrap, the digit index advances; it goes from NUM_DIGITS-1 back to 0.
  - anode, seg and dp are registered: they reflect the index one clock after it changes.
  - Exactly one anode is low at any time after the first clock following reset.
- Segment codes (active low, order a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- dp = ~dp_mask_captured[index].
- Reset asserted mid-conversion aborts it. Display returns to reset values; no partial result is kept.

Optional Feature:
SEVSEG_BLANK_EN
- Defined: leading zero blanking. A digit is blanked (seg=7'h7F) if it and every higher digit is 0. Digit 0 is never blanked. Blanking is off while overflow=1. dp is unaffected.
- Undefined: all digits are always shown, including leading zeros.

Test Plan:
1. Use REFRESH_BITS=2 for all tests. Hold reset_n=0 -> anode=4'hF, seg=7'h7F, dp=1, busy=0. Release -> anode cycles 1110, 1101, 1011, 0111, changing every 4 clocks.
2. Decimal load of value=1234 -> busy high for 17 clocks. Then digit 3..0 seg = 1001111, 0010010, 0000110, 1001100; overflow=0.
3. Hex load of value=16'hBEEF -> busy high 1 clock. Digits show b, E, E, F; overflow=0.
4. Decimal load of value=12345 with NUM_DIGITS=4 -> overflow=1; all digits show 1111110.
5. Load 42 at t, then load 7 at t+3 while busy -> display shows 42, then 7 after a further 17 clocks with no IDLE cycle in between. With SEVSEG_BLANK_EN, digits 3..1 show 7'h7F and digit 0 shows 7.
6. Load 9999, then reset_n=0 at clock 8 of the conversion -> all outputs at reset values. After release, the display shows 0000 (blanked to "   0" with SEVSEG_BLANK_EN).

Source files
------------

// File: rtl/seven_segment_mux.sv
// seven_segment_mux: N-digit multiplexed 7-segment driver with a sequential double-dabble converter.
// Define SEVSEG_BLANK_EN to enable leading-zero blanking.
module seven_segment_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int DATA_W       = 16,
    parameter int REFRESH_BITS = 18
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     value,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg,
    output logic                  dp
);
    localparam int BCD_DIGITS = (DATA_W * 302 + 999) / 1000 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W      = $clog2(DATA_W + 1);
    localparam int BEXT_W     = BCD_W + DISP_W;
    localparam int HEXT_W     = DATA_W + DISP_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            4'hF:    s = 7'b0111000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_W-1:0]       r_shift;
    logic [BCD_W-1:0]        r_bcd;
    logic                    r_cap_hex;
    logic [NUM_DIGITS-1:0]   r_cap_dp;
    logic                    r_pend;
    logic [DATA_W-1:0]       r_pend_val;
    logic                    r_pend_hex;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [DISP_W-1:0]       r_disp;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_disp_ovf;
    logic                    r_busy;
    logic [REFRESH_BITS-1:0] r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_seg;
    logic                    r_dp;

    logic                    w_capture;
    logic                    w_step;
    logic                    w_commit;
    logic [DATA_W-1:0]       w_src_val;
    logic                    w_src_hex;
    logic [NUM_DIGITS-1:0]   w_src_dp;
    logic [BCD_W-1:0]        w_adj;
    logic [BEXT_W-1:0]       w_bcd_ext;
    logic [HEXT_W-1:0]       w_hex_ext;
    logic [DISP_W-1:0]       w_new_disp;
    logic                    w_new_ovf;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_digit;
    logic                    w_blank_cur;
    logic                    w_dp_cur;
    logic [NUM_DIGITS-1:0]   w_anode_nx;
    logic [6:0]              w_seg_nx;

    // A load in the current cycle always beats the pending copy (last load wins).
    always_comb begin
        if (load) begin
            w_src_val = value;
            w_src_hex = hex_mode;
            w_src_dp  = dp_mask;
        end else begin
            w_src_val = r_pend_val;
            w_src_hex = r_pend_hex;
            w_src_dp  = r_pend_dp;
        end
    end

    // Converter state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Converter next-state logic; DONE chains directly into the next capture.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_state_nx = hex_mode ? S_DONE : S_SHIFT;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = S_SHIFT;
                end
            end
            S_DONE: begin
                if (load || r_pend) begin
                    w_state_nx = w_src_hex ? S_DONE : S_SHIFT;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Converter control strobes.
    always_comb begin
        w_capture = 1'b0;
        w_step    = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            S_IDLE:  w_capture = load;
            S_SHIFT: w_step = 1'b1;
            S_DONE: begin
                w_commit  = 1'b1;
                w_capture = load | r_pend;
            end
            default: w_capture = 1'b0;
        endcase
    end

    assign w_adj = dd_adjust(r_bcd);

    // Capture operands and run one double-dabble step per SHIFT cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_cap_hex <= 1'b0;
            r_cap_dp  <= '0;
        end else if (w_capture) begin
            r_shift   <= w_src_val;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_cap_hex <= w_src_hex;
            r_cap_dp  <= w_src_dp;
        end else if (w_step) begin
            r_bcd   <= {w_adj[BCD_W-2:0], r_shift[DATA_W-1]};
            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            r_cnt   <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // One-deep pending slot for loads that arrive while a conversion is running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_pend_hex <= 1'b0;
            r_pend_dp  <= '0;
        end else if (w_capture) begin
            r_pend <= 1'b0;
        end else if (load && (r_state != S_IDLE)) begin
            r_pend     <= 1'b1;
            r_pend_val <= value;
            r_pend_hex <= hex_mode;
            r_pend_dp  <= dp_mask;
        end else begin
            r_pend <= r_pend;
        end
    end

    // Zero-extend both result forms so any digit count can be sliced and overflow-checked.
    always_comb begin
        w_bcd_ext = '0;
        w_bcd_ext[BCD_W-1:0] = r_bcd;
        w_hex_ext = '0;
        w_hex_ext[DATA_W-1:0] = r_shift;
        if (r_cap_hex) begin
            w_new_disp = w_hex_ext[DISP_W-1:0];
            w_new_ovf  = |(w_hex_ext >> DISP_W);
        end else begin
            w_new_disp = w_bcd_ext[DISP_W-1:0];
            w_new_ovf  = |(w_bcd_ext >> DISP_W);
        end
    end

    // Display register: updated atomically so the scan never sees a partial result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp     <= '0;
            r_disp_dp  <= '0;
            r_disp_ovf <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_commit) begin
                r_disp     <= w_new_disp;
                r_disp_dp  <= r_cap_dp;
                r_disp_ovf <= w_new_ovf;
            end else begin
                r_disp_ovf <= r_disp_ovf;
            end
            r_busy <= (w_state_nx != S_IDLE);
        end
    end

`ifdef SEVSEG_BLANK_EN
    logic w_zero_above;

    // A digit blanks only if it and every digit to its left are zero.
    always_comb begin
        w_zero_above = 1'b1;
        w_blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (r_disp[4*i +: 4] != 4'd0) begin
                w_zero_above = 1'b0;
            end else begin
                w_zero_above = w_zero_above;
            end
            w_blank[i] = w_zero_above & ~r_disp_ovf;
        end
    end
`else
    assign w_blank = '0;
`endif

    // Select the current digit and build the next anode/segment/dp values.
    always_comb begin
        w_digit     = 4'd0;
        w_blank_cur = 1'b0;
        w_dp_cur    = 1'b0;
        w_anode_nx  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit       = r_disp[4*i +: 4];
                w_blank_cur   = w_blank[i];
                w_dp_cur      = r_disp_dp[i];
                w_anode_nx[i] = 1'b0;
            end else begin
                w_anode_nx[i] = 1'b1;
            end
        end
        if (r_disp_ovf) begin
            w_seg_nx = 7'b1111110;
        end else if (w_blank_cur) begin
            w_seg_nx = 7'h7F;
        end else begin
            w_seg_nx = seg_decode(w_digit);
        end
    end

    // Refresh prescaler and digit index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= r_presc + REFRESH_BITS'(1);
            if (&r_presc) begin
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_idx <= r_idx;
            end
        end
    end

    // Registered display pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_anode <= '1;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
        end else begin
            r_anode <= w_anode_nx;
            r_seg   <= w_seg_nx;
            r_dp    <= ~w_dp_cur;
        end
    end

    assign busy     = r_busy;
    assign overflow = r_disp_ovf;
    assign anode    = r_anode;
    assign seg      = r_seg;
    assign dp       = r_dp;
endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed self-checking bench for seven_segment_mux (4 digits, 16-bit value, 4-clock digit period).
module tb_seven_segment_mux;
    localparam logic [6:0] S0   = 7'b0000001;
    localparam logic [6:0] S1   = 7'b1001111;
    localparam logic [6:0] S2   = 7'b0010010;
    localparam logic [6:0] S3   = 7'b0000110;
    localparam logic [6:0] S4   = 7'b1001100;
    localparam logic [6:0] S7   = 7'b0001111;
    localparam logic [6:0] SB   = 7'b1100000;
    localparam logic [6:0] SE   = 7'b0110000;
    localparam logic [6:0] SF   = 7'b0111000;
    localparam logic [6:0] DASH = 7'b1111110;
    localparam logic [6:0] OFF  = 7'h7F;

    logic        clk;
    logic        reset_n;
    logic [15:0] value;
    logic        load;
    logic        hex_mode;
    logic [3:0]  dp_mask;
    logic        busy;
    logic        overflow;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;

    int checks;
    int errors;

    seven_segment_mux #(
        .NUM_DIGITS(4),
        .DATA_W(16),
        .REFRESH_BITS(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .value(value),
        .load(load),
        .hex_mode(hex_mode),
        .dp_mask(dp_mask),
        .busy(busy),
        .overflow(overflow),
        .anode(anode),
        .seg(seg),
        .dp(dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_load(input logic [15:0] v, input logic hx, input logic [3:0] dpm);
        @(negedge clk);
        value    = v;
        hex_mode = hx;
        dp_mask  = dpm;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        reset_n = 1'b0;
        load = 1'b0; value = 16'd0; hex_mode = 1'b0; dp_mask = 4'd0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (anode !== 4'hF) begin errors++; $display("FAIL reset_anode: got %h expected %h", anode, 4'hF); end
        if (seg !== OFF) begin errors++; $display("FAIL reset_seg: got %b expected %b", seg, OFF); end
        if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", dp); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_an = 4'b1111;
            exp_an[(k - 1) / 4] = 1'b0;
            checks++;
            if (anode !== exp_an) begin
                errors++;
                $display("FAIL scan_anode cycle %0d: got %b expected %b", k, anode, exp_an);
            end
        end
    endtask

    task automatic test_decimal();
        logic [6:0] exp_seg [4];
        int n;
        int idx;
        exp_seg[3] = S1; exp_seg[2] = S2; exp_seg[1] = S3; exp_seg[0] = S4;
        do_load(16'd1234, 1'b0, 4'b0000);
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        checks += 2;
        if (n !== 17) begin errors++; $display("FAIL dec_busy_cycles: got %0d expected 17", n); end
        @(negedge clk);
        if (overflow !== 1'b0) begin errors++; $display("FAIL dec_ovf: got %b expected 0", overflow); end
        for (int k = 0; k < 16; k++) begin
            idx = -1;
            for (int i = 0; i < 4; i++) if (anode[i] === 1'b0) idx = i;
            checks++;
            if (idx < 0) begin
                errors++; $display("FAIL dec_anode: got %b expected one low bit", anode);
            end else if (seg !== exp_seg[idx] || dp !== 1'b1) begin
                errors++; $display("FAIL dec_digit%0d: got seg %b dp %b expected seg %b dp 1", idx, seg, dp, exp_seg[idx]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hex();
        logic [6:0] exp_seg [4];
        logic [3:0] dpm;
        int n;
        int idx;
        exp_seg[3] = SB; exp_seg[2] = SE; exp_seg[1] = SE; exp_seg[0] = SF;
        dpm = 4'b0101;
        do_load(16'hBEEF, 1'b1, dpm);
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        checks += 2;
        if (n !== 1) begin errors++; $display("FAIL hex_busy_cycles: got %0d expected 1", n); end
        @(negedge clk);
        if (overflow !== 1'b0) begin errors++; $display("FAIL hex_ovf: got %b expected 0", overflow); end
        for (int k = 0; k < 16; k++) begin
            idx = -1;
            for (int i = 0; i < 4; i++) if (anode[i] === 1'b0) idx = i;
            checks++;
            if (idx < 0) begin
                errors++; $display("FAIL hex_anode: got %b expected one low bit", anode);
            end else if (seg !== exp_seg[idx] || dp !== ~dpm[idx]) begin
                errors++; $display("FAIL hex_digit%0d: got seg %b dp %b expected seg %b dp %b", idx, seg, dp, exp_seg[idx], ~dpm[idx]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] dpm;
        int n;
        int idx;
        dpm = 4'b1000;
        do_load(16'd12345, 1'b0, dpm);
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        @(negedge clk);
        checks += 2;
        if (n !== 17) begin errors++; $display("FAIL ovf_busy_cycles: got %0d expected 17", n); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        for (int k = 0; k < 16; k++) begin
            idx = -1;
            for (int i = 0; i < 4; i++) if (anode[i] === 1'b0) idx = i;
            checks++;
            if (idx < 0) begin
                errors++; $display("FAIL ovf_anode: got %b expected one low bit", anode);
            end else if (seg !== DASH || dp !== ~dpm[idx]) begin
                errors++; $display("FAIL ovf_digit%0d: got seg %b dp %b expected seg %b dp %b", idx, seg, dp, DASH, ~dpm[idx]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp42 [4];
        logic [6:0] exp7 [4];
        int busy_cnt;
        int first_idle;
        int idx;
`ifdef SEVSEG_BLANK_EN
        exp42[3] = OFF; exp42[2] = OFF; exp7[3] = OFF; exp7[2] = OFF; exp7[1] = OFF;
`else
        exp42[3] = S0; exp42[2] = S0; exp7[3] = S0; exp7[2] = S0; exp7[1] = S0;
`endif
        exp42[1] = S4; exp42[0] = S2; exp7[0] = S7;
        busy_cnt = 0;
        first_idle = -1;
        @(negedge clk);
        value = 16'd42; hex_mode = 1'b0; dp_mask = 4'd0; load = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) load = 1'b0;
            if (k == 2) begin value = 16'd7; load = 1'b1; end
            if (k == 3) load = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            else if (first_idle < 0) first_idle = k;
            if (k >= 18 && k <= 33) begin
                idx = -1;
                for (int i = 0; i < 4; i++) if (anode[i] === 1'b0) idx = i;
                checks++;
                if (idx < 0 || seg !== exp42[idx]) begin
                    errors++; $display("FAIL b2b_first_value: anode %b got seg %b", anode, seg);
                end
            end
        end
        checks += 3;
        if (busy_cnt !== 34) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 34", busy_cnt); end
        if (first_idle !== 34) begin errors++; $display("FAIL b2b_first_idle: got %0d expected 34", first_idle); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", overflow); end
        for (int k = 0; k < 16; k++) begin
            idx = -1;
            for (int i = 0; i < 4; i++) if (anode[i] === 1'b0) idx = i;
            checks++;
            if (idx < 0) begin
                errors++; $display("FAIL b2b_anode: got %b expected one low bit", anode);
            end else if (seg !== exp7[idx]) begin
                errors++; $display("FAIL b2b_second_digit%0d: got %b expected %b", idx, seg, exp7[idx]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        logic [6:0] exp_seg [4];
        int idx;
`ifdef SEVSEG_BLANK_EN
        exp_seg[3] = OFF; exp_seg[2] = OFF; exp_seg[1] = OFF;
`else
        exp_seg[3] = S0; exp_seg[2] = S0; exp_seg[1] = S0;
`endif
        exp_seg[0] = S0;
        do_load(16'd9999, 1'b0, 4'b1111);
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
        reset_n = 1'b0;
        #1;
        checks += 5;
        if (anode !== 4'hF) begin errors++; $display("FAIL abort_anode: got %h expected %h", anode, 4'hF); end
        if (seg !== OFF) begin errors++; $display("FAIL abort_seg: got %b expected %b", seg, OFF); end
        if (dp !== 1'b1) begin errors++; $display("FAIL abort_dp: got %b expected 1", dp); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf: got %b expected 0", overflow); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            idx = -1;
            for (int i = 0; i < 4; i++) if (anode[i] === 1'b0) idx = i;
            checks++;
            if (idx < 0) begin
                errors++; $display("FAIL abort_scan_anode: got %b expected one low bit", anode);
            end else if (seg !== exp_seg[idx] || dp !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL abort_digit%0d: got seg %b dp %b busy %b expected seg %b dp 1 busy 0", idx, seg, dp, busy, exp_seg[idx]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_decimal();
        test_hex();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
